// File: rtl/mc8051_mem_seq_pkg.sv
// Shared encodings for the mc8051 memory access sequencer: bus spaces,
// sequencer states, phase tags and the latched request record.
package mc8051_mem_seq_pkg;

  localparam logic [1:0] MEM_SP_CODE = 2'b00;
  localparam logic [1:0] MEM_SP_IRAM = 2'b01;
  localparam logic [1:0] MEM_SP_SFR  = 2'b10;
  localparam logic [1:0] MEM_SP_XRAM = 2'b11;

  typedef enum logic {
    MSEQ_IDLE   = 1'b0,
    MSEQ_ACCESS = 1'b1
  } mseq_state_e;

  typedef enum logic [1:0] {
    MSEQ_PH_S1 = 2'd0,
    MSEQ_PH_S2 = 2'd1,
    MSEQ_PH_S3 = 2'd2,
    MSEQ_PH_S5 = 2'd3
  } mseq_phase_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  space;
    logic [7:0]  wdata;
    mseq_phase_e phase;
  } mseq_req_t;

  // Number of phase requests raised in the same cycle.
  function automatic logic [2:0] req_count(input logic [3:0] reqs);
    return 3'(reqs[0]) + 3'(reqs[1]) + 3'(reqs[2]) + 3'(reqs[3]);
  endfunction

endpackage

// File: rtl/mc8051_mem_seq_bus_timer.sv
// Saturating 16-bit bus watchdog: cleared while idle, counts ready-low cycles,
// and expires once TIMEOUT_CYC of them have elapsed (never when TIMEOUT_CYC is 0).
module mc8051_bus_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (TIMEOUT_CYC != 0) && (cnt_q >= LIMIT);

endmodule

// File: rtl/mc8051_mem_seq.sv
// mc8051 memory access sequencer: latches one phase-tagged request, runs a
// ready-handshaked bus transaction, and returns read data to the phase buffers.
module mc8051_mem_seq
  import mc8051_mem_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_s1_req,
  input  logic        i_s2_req,
  input  logic        i_s3_req,
  input  logic        i_s5_req,
  input  logic [15:0] i_s1_mem_addr,
  input  logic [15:0] i_s2_mem_addr_d,
  input  logic [15:0] i_s3_mem_addr_d,
  input  logic [15:0] i_s5_mem_addr_d,
  input  logic [7:0]  i_mem_wdata,
  input  logic [1:0]  i_mem_space,
  output logic [15:0] o_mem_addr,
  output logic [1:0]  o_mem_space,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [7:0]  o_s1_instr_buffer,
  output logic [7:0]  o_s2_data_buffer,
  output logic [7:0]  o_s3_data_buffer,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_bus_err,
  output logic        o_proto_err
);

  mseq_state_e state_q, state_d;
  mseq_req_t   cur_q, cur_d;
  mseq_req_t   sel_req;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        bus_err_q, bus_err_d;
  logic        proto_err_q, proto_err_d;
  logic [7:0]  s1_buf_q, s1_buf_d;
  logic [7:0]  s2_buf_q, s2_buf_d;
  logic [7:0]  s3_buf_q, s3_buf_d;
  logic [7:0]  ret_data;
  logic [3:0]  reqs;
  logic        timer_clr, timer_en, timer_expire;

  assign reqs = {i_s5_req, i_s3_req, i_s2_req, i_s1_req};

  // Priority select: later assignments win, so S1 overrides everything.
  always_comb begin
    sel_req.space = i_mem_space;
    sel_req.wdata = i_mem_wdata;
    sel_req.addr  = i_s5_mem_addr_d;
    sel_req.phase = MSEQ_PH_S5;
    if (i_s3_req) begin
      sel_req.addr  = i_s3_mem_addr_d;
      sel_req.phase = MSEQ_PH_S3;
    end
    if (i_s2_req) begin
      sel_req.addr  = i_s2_mem_addr_d;
      sel_req.phase = MSEQ_PH_S2;
    end
    if (i_s1_req) begin
      sel_req.addr  = i_s1_mem_addr;
      sel_req.phase = MSEQ_PH_S1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    done_d      = 1'b0;
    bus_err_d   = bus_err_q;
    proto_err_d = proto_err_q;
    s1_buf_d    = s1_buf_q;
    s2_buf_d    = s2_buf_q;
    s3_buf_d    = s3_buf_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    ret_data    = i_mem_ready ? i_mem_rdata : 8'hFF;

    case (state_q)
      MSEQ_IDLE: begin
        timer_clr = 1'b1;
        if (|reqs) begin
          cur_d   = sel_req;
          rd_d    = (sel_req.phase != MSEQ_PH_S5);
          wr_d    = (sel_req.phase == MSEQ_PH_S5);
          state_d = MSEQ_ACCESS;
          if (req_count(reqs) > 3'd1) begin
            proto_err_d = 1'b1;
          end
        end
      end

      MSEQ_ACCESS: begin
        timer_en = !i_mem_ready;
        if (|reqs) begin
          proto_err_d = 1'b1;
        end
        // A timed-out write simply completes; nothing lands anywhere.
        if (i_mem_ready || timer_expire) begin
          if (!i_mem_ready) begin
            bus_err_d = 1'b1;
          end
          case (cur_q.phase)
            MSEQ_PH_S1: s1_buf_d = ret_data;
            MSEQ_PH_S2: s2_buf_d = ret_data;
            MSEQ_PH_S3: s3_buf_d = ret_data;
            default:    ;
          endcase
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = MSEQ_IDLE;
        end
      end

      default: state_d = MSEQ_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= MSEQ_IDLE;
      cur_q       <= '{addr: 16'h0000, space: MEM_SP_CODE, wdata: 8'h00, phase: MSEQ_PH_S1};
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      s1_buf_q    <= 8'h00;
      s2_buf_q    <= 8'h00;
      s3_buf_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      proto_err_q <= proto_err_d;
      s1_buf_q    <= s1_buf_d;
      s2_buf_q    <= s2_buf_d;
      s3_buf_q    <= s3_buf_d;
    end
  end

  mc8051_bus_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_bus_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (timer_clr),
    .i_en     (timer_en),
    .o_expire (timer_expire)
  );

  assign o_mem_addr        = cur_q.addr;
  assign o_mem_space       = cur_q.space;
  assign o_mem_wdata       = cur_q.wdata;
  assign o_mem_rd          = rd_q;
  assign o_mem_wr          = wr_q;
  assign o_stall           = (state_q == MSEQ_ACCESS);
  assign o_done            = done_q;
  assign o_bus_err         = bus_err_q;
  assign o_proto_err       = proto_err_q;
  assign o_s1_instr_buffer = s1_buf_q;
  assign o_s2_data_buffer  = s2_buf_q;
  assign o_s3_data_buffer  = s3_buf_q;

endmodule
